// File: rtl/w_full.sv
// Write-side pointer and flag logic of an asynchronous FIFO.
// Keeps the binary/Gray write pointer and derives full, almost-full, level and overflow.
module w_full #(
  parameter int ADDR_SIZE = 3,
  parameter int AF_MARGIN = (2 ** ADDR_SIZE) >> 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE:0]   r_ptr,
  input  logic                 w_en,
  input  logic                 clr_ovf,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic [ADDR_SIZE:0]   w_ptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   w_level,
  output logic                 overflow
);

  localparam int MEM_SIZE = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AF_THRESH = (ADDR_SIZE + 1)'(MEM_SIZE - AF_MARGIN);

  logic [ADDR_SIZE:0] w_bin_reg;
  logic [ADDR_SIZE:0] w_bin_next;
  logic [ADDR_SIZE:0] w_gray_next;
  logic [ADDR_SIZE:0] r_bin;
  logic [ADDR_SIZE:0] level_next;
  logic [ADDR_SIZE:0] full_gray;
  logic               write_ok;
  logic               full_next;

  assign write_ok    = w_en & ~full;
  assign w_bin_next  = w_bin_reg + {{ADDR_SIZE{1'b0}}, write_ok};
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);
  assign w_addr      = w_bin_reg[ADDR_SIZE-1:0];

  // Each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi <= ADDR_SIZE; gi++) begin : g_gray2bin
      assign r_bin[gi] = ^r_ptr[ADDR_SIZE:gi];
    end
  endgenerate

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign full_gray  = {~r_ptr[ADDR_SIZE:ADDR_SIZE-1], r_ptr[ADDR_SIZE-2:0]};
  assign full_next  = (w_gray_next == full_gray);
  assign level_next = w_bin_next - r_bin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_bin_reg   <= '0;
      w_ptr       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      w_level     <= '0;
      overflow    <= 1'b0;
    end else begin
      w_bin_reg   <= w_bin_next;
      w_ptr       <= w_gray_next;
      full        <= full_next;
      almost_full <= (level_next >= AF_THRESH) | full_next;
      w_level     <= level_next;
      if (w_en && full)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_w_full.sv
// Self-checking bench for w_full: directed scenarios plus randomized traffic
// compared against a count-based model of the FIFO write side.
module tb_w_full;

  localparam int ADDR_SIZE = 3;
  localparam int AF_MARGIN = 2;
  localparam int MEM       = 2 ** ADDR_SIZE;

  logic                 clk;
  logic                 rst;
  logic [ADDR_SIZE:0]   r_ptr;
  logic                 w_en;
  logic                 clr_ovf;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [ADDR_SIZE:0]   w_ptr;
  logic                 full;
  logic                 almost_full;
  logic [ADDR_SIZE:0]   w_level;
  logic                 overflow;

  w_full #(.ADDR_SIZE(ADDR_SIZE), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .rst(rst), .r_ptr(r_ptr), .w_en(w_en), .clr_ovf(clr_ovf),
    .w_addr(w_addr), .w_ptr(w_ptr), .full(full), .almost_full(almost_full),
    .w_level(w_level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: total words written and read since reset, plus sticky error.
  int wr = 0;
  int rd = 0;
  bit exp_full = 0;
  bit exp_af   = 0;
  bit exp_ovf  = 0;
  int exp_lvl  = 0;
  logic [ADDR_SIZE:0] prev_ptr = '0;

  function automatic logic [ADDR_SIZE:0] to_gray(input int b);
    logic [ADDR_SIZE:0] v;
    v = ADDR_SIZE'(0) + (ADDR_SIZE + 1)'(b % (2 * MEM));
    return v ^ (v >> 1);
  endfunction

  always_comb r_ptr = to_gray(rd);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".w_addr"}, 32'(w_addr), 32'(wr % MEM));
    check({tag, ".w_ptr"}, 32'(w_ptr), 32'(to_gray(wr)));
    check({tag, ".full"}, 32'(full), 32'(exp_full));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(exp_af));
    check({tag, ".w_level"}, 32'(w_level), 32'(exp_lvl));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic model_reset();
    wr = 0; rd = 0; exp_full = 0; exp_af = 0; exp_ovf = 0; exp_lvl = 0;
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then compare.
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (!rst) begin
      model_reset();
    end else begin
      if (w_en && exp_ovf == exp_ovf && exp_full) exp_ovf = 1;
      else if (clr_ovf) exp_ovf = 0;
      if (w_en && !exp_full) wr++;
      exp_lvl  = wr - rd;
      exp_full = (exp_lvl == MEM);
      exp_af   = (exp_lvl >= MEM - AF_MARGIN);
    end
    check_all(tag);
    check({tag, ".gray_step"}, 32'($countones(w_ptr ^ prev_ptr) <= 1), 32'd1);
    $display("%s: w_en=%0b clr=%0b r_ptr=%b -> w_ptr=%b lvl=%0d full=%0b af=%0b ovf=%0b",
             tag, w_en, clr_ovf, r_ptr, w_ptr, w_level, full, almost_full, overflow);
    prev_ptr = w_ptr;
  endtask

  initial begin
    rst = 1'b0; w_en = 1'b1; clr_ovf = 1'b0;
    model_reset();

    // Reset held with writes requested and clocks running.
    repeat (3) tick("reset");
    rst = 1'b1;
    tick("first_wr");
    check("first_wr.addr1", 32'(w_addr), 32'd1);
    check("first_wr.ptr0001", 32'(w_ptr), 32'b0001);

    // Fill from empty with the reader parked at zero.
    rst = 1'b0; #1; model_reset(); prev_ptr = '0;
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 1; i <= MEM; i++) begin
      tick($sformatf("fill%0d", i));
      check("fill.af_edge", 32'(almost_full), 32'(i >= 6));
    end
    check("fill.ptr1100", 32'(w_ptr), 32'b1100);
    check("fill.lvl8", 32'(w_level), 32'd8);

    // Overflow: rejected write, hold, clear, set-beats-clear.
    tick("ovf_set");
    check("ovf.ptr_hold", 32'(w_ptr), 32'b1100);
    w_en = 1'b0;
    tick("ovf_hold");
    clr_ovf = 1'b1;
    tick("ovf_clr");
    w_en = 1'b1;
    tick("ovf_setwin");
    check("ovf.setwin", 32'(overflow), 32'd1);
    w_en = 1'b0; clr_ovf = 1'b0;

    // Drain three entries.
    rd = 3;
    tick("drain");
    check("drain.lvl5", 32'(w_level), 32'd5);
    check("drain.full0", 32'(full), 32'd0);
    clr_ovf = 1'b1;
    tick("drain_clr");
    clr_ovf = 1'b0;

    // Wrap: reader trails by one entry across more than two laps.
    w_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rd = wr;
      tick($sformatf("wrap%0d", i));
      check("wrap.lvl1", 32'(w_level), 32'd1);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      w_en    = ($urandom % 4) != 0;
      clr_ovf = ($urandom % 8) == 0;
      if ($urandom % 3 == 0) rd = rd + $urandom_range(0, wr - rd);
      tick($sformatf("rnd%0d", i));
    end

    // Fill to full with an error pending, then reset asynchronously mid-cycle.
    clr_ovf = 1'b0; w_en = 1'b1;
    for (int i = 0; i < 2 * MEM && !(exp_full && exp_ovf); i++) tick("prefill");
    check("mid.full_before", 32'(full), 32'd1);
    check("mid.ovf_before", 32'(overflow), 32'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("mid_async");
    prev_ptr = w_ptr;
    tick("mid_held");
    #1 rst = 1'b1;
    tick("mid_release");
    check("mid_release.lvl1", 32'(w_level), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/w_full.md
W_FULL -- requirements
Module: w_full

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 3, memory address width; MEM_SIZE = 2**ADDR_SIZE; legal range ADDR_SIZE >= 2.
REQ-002 SHALL have parameter AF_MARGIN, default MEM_SIZE>>2, free-slot threshold for almost_full; legal range 1..MEM_SIZE-1.
REQ-003 SHALL have port clk, input, 1, write clock; all state on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port r_ptr, input, ADDR_SIZE+1, Gray read pointer already synchronized to clk.
REQ-006 SHALL have port w_en, input, 1, write request.
REQ-007 SHALL have port clr_ovf, input, 1, clear sticky overflow.
REQ-008 SHALL have port w_addr, output, ADDR_SIZE, memory write address.
REQ-009 SHALL have port w_ptr, output, ADDR_SIZE+1, registered Gray write pointer for the read-domain synchronizer.
REQ-010 SHALL have port full, output, 1, registered full flag.
REQ-011 SHALL have port almost_full, output, 1, registered almost-full flag.
REQ-012 SHALL have port w_level, output, ADDR_SIZE+1, registered fill count (0..MEM_SIZE).
REQ-013 SHALL have port overflow, output, 1, sticky write-while-full error.

Function
REQ-014 SHALL hold binary write counter w_bin (ADDR_SIZE+1 bits); w_addr = w_bin[ADDR_SIZE-1:0], combinational from the register.
REQ-015 SHALL compute w_bin_next = w_bin + (w_en & ~full), modulo 2**(ADDR_SIZE+1); a write is accepted only when w_en=1 and full=0.
REQ-016 SHALL compute w_gray_next = w_bin_next ^ (w_bin_next >> 1), and register w_bin <= w_bin_next, w_ptr <= w_gray_next every edge.
REQ-017 SHALL decode r_bin from r_ptr by Gray-to-binary (prefix XOR from MSB).
REQ-018 SHALL register full <= (w_gray_next == {~r_ptr[ADDR_SIZE:ADDR_SIZE-1], r_ptr[ADDR_SIZE-2:0]}).
REQ-019 SHALL register w_level <= (w_bin_next - r_bin) modulo 2**(ADDR_SIZE+1).
REQ-020 SHALL register almost_full <= (w_bin_next - r_bin) >= MEM_SIZE - AF_MARGIN; almost_full SHALL be 1 whenever full is 1.
REQ-021 SHALL register overflow <= 1 when w_en=1 and full=1; else 0 when clr_ovf=1; else hold; set wins over a simultaneous clear.
REQ-022 SHALL leave w_bin, w_ptr, and w_addr unchanged on a rejected write (w_en=1, full=1).
REQ-023 SHALL wrap w_bin from 2**(ADDR_SIZE+1)-1 to 0 with no change to flag semantics.
REQ-024 SHALL deassert full the edge after r_ptr advances past the full point, with no write accepted in that same edge.
REQ-025 SHALL allow a write and a read-pointer advance in the same cycle; the level then remains net unchanged.
REQ-026 SHALL change at most one bit of w_ptr per clock (Gray property).

Reset
REQ-027 SHALL, while rst=0, force w_bin=0, w_ptr=0, full=0, almost_full=0, w_level=0, overflow=0, independent of clk; w_addr SHALL then read 0.
REQ-028 SHALL resume normal operation on the first posedge after rst deasserts, and SHALL discard any in-flight write at reset assertion.

Verification (ADDR_SIZE=3, AF_MARGIN=2)
REQ-029 SHALL cover reset: rst=0 with w_en=1 and clocks running -> all outputs 0; release -> first write sets w_addr=1, w_ptr=4'b0001, w_level=1.
REQ-030 SHALL cover fill: r_ptr=0, w_en=1 for 8 edges -> almost_full=1 after 6th edge, full=1 after 8th, w_ptr=4'b1100, w_level=8.
REQ-031 SHALL cover overflow: 9th w_en while full -> w_ptr stays 4'b1100, overflow=1 and holds; clr_ovf=1 one cycle -> overflow=0; w_en=1 plus clr_ovf=1 while full -> overflow=1.
REQ-032 SHALL cover drain: from full, r_ptr=4'b0010 (3 reads) -> next edge full=0, almost_full=0, w_level=5.
REQ-033 SHALL cover wrap: 16+ writes with r_ptr trailing by one entry -> w_ptr goes 4'b1000 -> 4'b0000, never full, w_level=1 throughout.
REQ-034 SHALL cover reset mid-operation: rst=0 while full=1 and overflow=1 -> all outputs 0 immediately, without a clock edge.
